// File: rtl/if_prefetch_queue_pkg.sv
// rtl/if_prefetch_queue_pkg.sv - shared types and constants for the fetch front end
//
// Purpose: types and constants used by the prefetch queue and its entry FIFO.
//   RESET_PC_DEFAULT  default first fetch address after reset
//   NOP               canonical no-op (addi x0,x0,0), shown on id_instr when empty
//   fetch_entry_t     one queue entry: {pc, instr}
//   align_pc()        clears the byte-offset bits of a PC
package if_prefetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_sync_fifo.sv
// rtl/if_prefetch_queue_sync_fifo.sv - DEPTH-entry synchronous FIFO with clear and count
//
// Purpose: storage for fetched {pc, instr} entries.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   push   in   write wdata at the tail
//   pop    in   drop the head entry
//   clear  in   empty the FIFO (overrides push and pop)
//   wdata  in   W-bit entry to write
//   rdata  out  W-bit head entry (undefined when count == 0)
//   count  out  occupancy, 0..DEPTH
module if_prefetch_queue_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_en;
  logic          push_en;
  logic          full;

  assign full    = (count == CNT_FULL);
  assign pop_en  = pop & (count != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_en = push & (~full | pop_en);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push_en && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction prefetch queue between IM and decode
//
// Purpose: issues sequential IM reads, queues returned words with their PCs and
// hands them to decode over valid/ready. Redirects flush the queue and any
// in-flight read, and restart fetch at the new PC in the same cycle.
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   im_req, im_addr     IM read enable and word address
//   im_rdata            IM data, valid the cycle after im_req
//   redirect, redirect_pc  control-flow change and new PC (bits [1:0] ignored)
//   id_ready            decode accepts head entry
//   id_valid, id_instr, id_pc  head entry to decode
//   q_count             queue occupancy
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IM_AW    = 14,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       im_req,
  output logic [IM_AW-1:0]           im_addr,
  input  logic [31:0]                im_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [31:0]                id_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] OCC_LIMIT = (CW + 1)'(DEPTH);

  logic [31:0]  fetch_pc;
  logic [31:0]  rsp_pc;
  logic         pending;
  logic [31:0]  redirect_al;
  logic         push;
  logic         pop;
  logic [CW:0]  occ_next;
  fetch_entry_t wr_entry;
  fetch_entry_t head;
  logic [CW-1:0] count;

  assign redirect_al = align_pc(redirect_pc);

  // A response arriving in a redirect cycle belongs to the old stream.
  assign push     = pending & ~redirect;
  assign id_valid = (count != '0) & ~redirect;
  assign pop      = id_valid & id_ready;

  // Slots committed after this cycle; issuing only while this is below DEPTH
  // reserves a slot for every outstanding response, so the queue cannot overflow.
  assign occ_next = {1'b0, count} + {{CW{1'b0}}, pending} - {{CW{1'b0}}, pop};

  // Gated by rst so no request leaves while reset is held.
  assign im_req  = ~rst & (redirect | (occ_next < OCC_LIMIT));
  assign im_addr = redirect ? redirect_pc[IM_AW+1:2] : fetch_pc[IM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      pending  <= 1'b0;
    end else begin
      pending <= im_req;
      if (redirect) begin
        rsp_pc   <= redirect_al;
        fetch_pc <= redirect_al + 32'd4;
      end else if (im_req) begin
        rsp_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  assign wr_entry.pc    = rsp_pc;
  assign wr_entry.instr = im_rdata;

  if_prefetch_queue_sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t)),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata (wr_entry),
    .rdata (head),
    .count (count)
  );

  // An empty queue presents a NOP rather than stale storage.
  assign id_instr = (count != '0) ? head.instr : NOP;
  assign id_pc    = head.pc;
  assign q_count  = count;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - directed and scoreboard bench for if_prefetch_queue
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req;
  logic [13:0] im_addr;
  logic [31:0] im_rdata = 32'hDEAD_BEEF;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  q_count;

  int tests = 0;
  int fails = 0;

  if_prefetch_queue #(.DEPTH(4), .IM_AW(14), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // IM model: word at address a holds a; garbage when no read was issued.
  always @(posedge clk) begin
    if (im_req) im_rdata <= {18'b0, im_addr};
    else        im_rdata <= 32'hDEAD_BEEF;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Holds rst over one edge, checks reset outputs, releases; returns in cycle 0.
  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect = 1'b0;
    id_ready = ready;
    @(posedge clk);
    #1;
    tests++;
    if (id_valid !== 1'b0 || im_req !== 1'b0 || q_count !== 3'd0) begin
      fails++;
      $display("FAIL reset_hold: valid=%b req=%b count=%0d want 0/0/0", id_valid, im_req, q_count);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    #1;
    tests++;
    if (im_req !== 1'b1 || im_addr !== 14'd0 || id_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: req=%b addr=%0h valid=%b want 1/0/0", im_req, im_addr, id_valid);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c != 0) cyc();
      #1;
      tests++;
      if (im_req !== 1'b1 || im_addr !== 14'(c)) begin
        fails++;
        $display("FAIL stream_req c=%0d: req=%b addr=%0h want 1/%0h", c, im_req, im_addr, c);
      end
      tests++;
      if (c < 2) begin
        if (id_valid !== 1'b0) begin
          fails++;
          $display("FAIL stream_early c=%0d: valid=%b want 0", c, id_valid);
        end
      end else if (id_valid !== 1'b1 || id_pc !== 32'((c - 2) * 4) || id_instr !== 32'(c - 2)) begin
        fails++;
        $display("FAIL stream_data c=%0d: valid=%b pc=%0h instr=%0h want 1/%0h/%0h",
                 c, id_valid, id_pc, id_instr, (c - 2) * 4, c - 2);
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c != 0) cyc();
      #1;
      if (im_req === 1'b1) begin
        tests++;
        if (im_addr !== 14'(nreq)) begin
          fails++;
          $display("FAIL bp_addr: addr=%0h want %0h", im_addr, nreq);
        end
        nreq++;
      end
    end
    tests++;
    if (nreq != 4) begin
      fails++;
      $display("FAIL bp_nreq: requests=%0d want 4", nreq);
    end
    tests++;
    if (q_count !== 3'd4 || im_req !== 1'b0) begin
      fails++;
      $display("FAIL bp_full: count=%0d req=%b want 4/0", q_count, im_req);
    end
    for (int k = 0; k < 10; k++) begin
      cyc();
      id_ready = 1'b1;
      #1;
      tests++;
      if (id_valid !== 1'b1 || id_pc !== 32'(k * 4) || id_instr !== 32'(k)) begin
        fails++;
        $display("FAIL bp_drain k=%0d: valid=%b pc=%0h instr=%0h want 1/%0h/%0h",
                 k, id_valid, id_pc, id_instr, k * 4, k);
      end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (4) cyc();
    #1;
    tests++;
    if (q_count !== 3'd3) begin
      fails++;
      $display("FAIL redir_pre: count=%0d want 3", q_count);
    end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    tests++;
    if (im_req !== 1'b1 || im_addr !== 14'h40 || id_valid !== 1'b0) begin
      fails++;
      $display("FAIL redir_issue: req=%b addr=%0h valid=%b want 1/40/0", im_req, im_addr, id_valid);
    end
    cyc();
    redirect = 1'b0;
    #1;
    tests++;
    if (q_count !== 3'd0 || id_valid !== 1'b0) begin
      fails++;
      $display("FAIL redir_flush: count=%0d valid=%b want 0/0", q_count, id_valid);
    end
    cyc();
    #1;
    tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h40) begin
      fails++;
      $display("FAIL redir_first: valid=%b pc=%0h instr=%0h want 1/100/40", id_valid, id_pc, id_instr);
    end
    id_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      #1;
      tests++;
      if (id_valid !== 1'b1 || id_pc !== 32'h100 + 32'(4 * k)) begin
        fails++;
        $display("FAIL redir_follow k=%0d: valid=%b pc=%0h want 1/%0h", k, id_valid, id_pc, 32'h100 + 4 * k);
      end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_full_redirect();
    do_reset(1'b0);
    repeat (6) cyc();
    #1;
    tests++;
    if (q_count !== 3'd4) begin
      fails++;
      $display("FAIL fullredir_pre: count=%0d want 4", q_count);
    end
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h203;
    #1;
    tests++;
    if (id_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 14'h80) begin
      fails++;
      $display("FAIL fullredir_issue: valid=%b req=%b addr=%0h want 0/1/80", id_valid, im_req, im_addr);
    end
    cyc();
    redirect = 1'b0;
    id_ready = 1'b0;
    #1;
    tests++;
    if (q_count !== 3'd0) begin
      fails++;
      $display("FAIL fullredir_count: count=%0d want 0", q_count);
    end
    cyc();
    #1;
    tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== 32'h80) begin
      fails++;
      $display("FAIL fullredir_first: valid=%b pc=%0h instr=%0h want 1/200/80", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    repeat (3) cyc();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    #1;
    tests++;
    if (im_addr !== 14'hC0) begin
      fails++;
      $display("FAIL b2b_first: addr=%0h want c0", im_addr);
    end
    cyc();
    redirect_pc = 32'h400;
    #1;
    tests++;
    if (im_addr !== 14'h100 || id_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: addr=%0h valid=%b want 100/0", im_addr, id_valid);
    end
    cyc();
    redirect = 1'b0;
    #1;
    tests++;
    if (id_valid !== 1'b0 || q_count !== 3'd0) begin
      fails++;
      $display("FAIL b2b_gap: valid=%b count=%0d want 0/0", id_valid, q_count);
    end
    cyc();
    #1;
    tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h400) begin
      fails++;
      $display("FAIL b2b_pc0: valid=%b pc=%0h want 1/400", id_valid, id_pc);
    end
    cyc();
    #1;
    tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h404) begin
      fails++;
      $display("FAIL b2b_pc1: valid=%b pc=%0h want 1/404", id_valid, id_pc);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    repeat (4) cyc();
    #1;
    tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h8) begin
      fails++;
      $display("FAIL areset_pre: valid=%b pc=%0h want 1/8", id_valid, id_pc);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (id_valid !== 1'b0 || im_req !== 1'b0 || q_count !== 3'd0) begin
      fails++;
      $display("FAIL areset_now: valid=%b req=%b count=%0d want 0/0/0", id_valid, im_req, q_count);
    end
    cyc();
    rst = 1'b0;
    #1;
    tests++;
    if (im_req !== 1'b1 || im_addr !== 14'd0 || id_valid !== 1'b0) begin
      fails++;
      $display("FAIL areset_restart: req=%b addr=%0h valid=%b want 1/0/0", im_req, im_addr, id_valid);
    end
    cyc();
    cyc();
    #1;
    tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      fails++;
      $display("FAIL areset_first: valid=%b pc=%0h want 1/0", id_valid, id_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int pops;
    exp_pc = 32'h0;
    pops = 0;
    do_reset(1'b1);
    for (int c = 0; c < 300; c++) begin
      if (c != 0) cyc();
      id_ready = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      #1;
      tests++;
      if (q_count > 3'd4) begin
        fails++;
        $display("FAIL rnd_count c=%0d: count=%0d want <=4", c, q_count);
      end
      if (redirect) begin
        tests++;
        if (id_valid !== 1'b0) begin
          fails++;
          $display("FAIL rnd_redir_valid c=%0d: valid=%b want 0", c, id_valid);
        end
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (id_valid === 1'b1 && id_ready) begin
        tests++;
        if (id_pc !== exp_pc || id_instr !== {18'b0, exp_pc[15:2]}) begin
          fails++;
          $display("FAIL rnd_pop c=%0d: pc=%0h instr=%0h want %0h/%0h",
                   c, id_pc, id_instr, exp_pc, {18'b0, exp_pc[15:2]});
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    redirect = 1'b0;
    id_ready = 1'b0;
    tests++;
    if (pops < 12) begin
      fails++;
      $display("FAIL rnd_pops: pops=%0d want >=12", pops);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_full_redirect();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
